// File: rtl/mips_pkg.sv
// ============================================================================
//  Module      : mips_pkg
//  Description : Shared types and constants for the MEM pipeline stage.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mips_pkg;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

  localparam int WAIT_W     = 3;
  localparam int WORD_BYTES = 4;

endpackage

`default_nettype wire

// File: rtl/dmem_array.sv
// ============================================================================
//  Module      : dmem_array
//  Description : Word-addressed data memory, asynchronous read, synchronous write.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dmem_array #(
  parameter int DEPTH_WORDS = 1024,
  parameter int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] r_mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (we) begin
      r_mem[addr] <= wdata;
    end
  end

  assign rdata = r_mem[addr];

endmodule

`default_nettype wire

// File: rtl/mem_stage_wb.sv
// ============================================================================
//  Module      : mem_stage_wb
//  Description : MEM stage with wait-state data memory, stall FSM and MEM/WB register.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_stage_wb
  import mips_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic        MemtoReg,
  input  logic        RegWrite,
  input  logic [31:0] ALU_out,
  input  logic [31:0] rd2,
  input  logic [4:0]  wn,
  output logic        stall,
  output logic        out_RegWrite,
  output logic        out_MemtoReg,
  output logic [31:0] out_rd,
  output logic [31:0] out_ALU_out,
  output logic [4:0]  out_wn,
  output logic        out_addr_err
);

  localparam int c_AW    = $clog2(DEPTH_WORDS);
  localparam int c_OFS_W = $clog2(WORD_BYTES);

  state_t              r_state;
  state_t              w_state_nxt;
  logic [WAIT_W-1:0]   r_cnt;
  logic [WAIT_W-1:0]   w_cnt_nxt;
  logic                w_stall;
  logic                w_mem_op;
  logic                w_misaligned;
  logic                w_is_store;
  logic                w_we;
  logic [c_AW-1:0]     w_index;
  logic [31:0]         w_rdata;
  logic                w_unused_addr;

  assign w_mem_op      = MemRead | MemWrite;
  assign w_misaligned  = |ALU_out[c_OFS_W-1:0];
  assign w_is_store    = MemWrite;
  assign w_index       = ALU_out[c_AW+c_OFS_W-1:c_OFS_W];
  // Address bits above the array wrap silently.
  assign w_unused_addr = ^ALU_out[31:c_AW+c_OFS_W];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_stall     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_mem_op && (WAIT_CYCLES != 0)) begin
          w_stall     = 1'b1;
          w_cnt_nxt   = WAIT_W'(WAIT_CYCLES - 1);
          w_state_nxt = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (r_cnt != '0) begin
          w_stall   = 1'b1;
          w_cnt_nxt = r_cnt - 1'b1;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign stall = w_stall;

  // Commit happens on any non-stalled edge; a reset edge aborts the store.
  assign w_we = w_is_store & ~w_misaligned & ~w_stall & ~rst;

  dmem_array #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .AW          (c_AW)
  ) u_dmem (
    .clk   (clk),
    .we    (w_we),
    .addr  (w_index),
    .wdata (rd2),
    .rdata (w_rdata)
  );

  always_ff @(posedge clk) begin
    if (rst || w_stall) begin
      out_RegWrite <= 1'b0;
      out_MemtoReg <= 1'b0;
      out_rd       <= '0;
      out_ALU_out  <= '0;
      out_wn       <= '0;
      out_addr_err <= 1'b0;
    end else begin
      out_RegWrite <= RegWrite & ~(w_mem_op & w_misaligned);
      out_MemtoReg <= MemtoReg;
      out_rd       <= (MemRead & ~MemWrite & ~w_misaligned) ? w_rdata : 32'h0;
      out_ALU_out  <= ALU_out;
      out_wn       <= wn;
      out_addr_err <= w_mem_op & w_misaligned;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mem_stage_wb.sv
// ============================================================================
//  Module      : tb_mem_stage_wb
//  Description : Directed self-checking bench for mem_stage_wb (2 and 0 wait states).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_stage_wb;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        MemRead = 1'b0, MemWrite = 1'b0, MemtoReg = 1'b0, RegWrite = 1'b0;
  logic [31:0] ALU_out = '0, rd2 = '0;
  logic [4:0]  wn = '0;

  logic        stall2, rw2, m2r2, err2;
  logic [31:0] rd_2, alu2;
  logic [4:0]  wn2;
  logic        stall0, rw0, m2r0, err0;
  logic [31:0] rd_0, alu0;
  logic [4:0]  wn0;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mem_stage_wb #(.DEPTH_WORDS(1024), .WAIT_CYCLES(2)) u_dut2 (
    .clk(clk), .rst(rst), .MemRead(MemRead), .MemWrite(MemWrite), .MemtoReg(MemtoReg),
    .RegWrite(RegWrite), .ALU_out(ALU_out), .rd2(rd2), .wn(wn), .stall(stall2),
    .out_RegWrite(rw2), .out_MemtoReg(m2r2), .out_rd(rd_2), .out_ALU_out(alu2),
    .out_wn(wn2), .out_addr_err(err2)
  );

  mem_stage_wb #(.DEPTH_WORDS(1024), .WAIT_CYCLES(0)) u_dut0 (
    .clk(clk), .rst(rst), .MemRead(MemRead), .MemWrite(MemWrite), .MemtoReg(MemtoReg),
    .RegWrite(RegWrite), .ALU_out(ALU_out), .rd2(rd2), .wn(wn), .stall(stall0),
    .out_RegWrite(rw0), .out_MemtoReg(m2r0), .out_rd(rd_0), .out_ALU_out(alu0),
    .out_wn(wn0), .out_addr_err(err0)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic mr, input logic mw, input logic m2r, input logic rw,
                       input logic [31:0] alu, input logic [31:0] d, input logic [4:0] w);
    MemRead = mr; MemWrite = mw; MemtoReg = m2r; RegWrite = rw;
    ALU_out = alu; rd2 = d; wn = w;
  endtask

  // Issue one instruction to the 2-wait-state DUT and check bubbles then the commit result.
  task automatic op2(input string tag, input logic mr, input logic mw, input logic m2r,
                     input logic rw, input logic [31:0] alu, input logic [31:0] d,
                     input logic [4:0] w, input logic exp_rw, input logic [31:0] exp_rd,
                     input logic exp_err);
    int nstall;
    nstall = (mr | mw) ? 2 : 0;
    drive(mr, mw, m2r, rw, alu, d, w);
    for (int i = 0; i < nstall; i++) begin
      @(negedge clk);
      chk({tag, "_stall_hi"}, 32'(stall2), 32'd1);
      @(posedge clk); #1;
      chk({tag, "_bubble_rw"}, 32'(rw2), 32'd0);
      chk({tag, "_bubble_wn"}, 32'(wn2), 32'd0);
    end
    @(negedge clk);
    chk({tag, "_stall_lo"}, 32'(stall2), 32'd0);
    @(posedge clk); #1;
    chk({tag, "_rw"}, 32'(rw2), 32'(exp_rw));
    chk({tag, "_m2r"}, 32'(m2r2), 32'(m2r));
    chk({tag, "_rd"}, rd_2, exp_rd);
    chk({tag, "_alu"}, alu2, alu);
    chk({tag, "_wn"}, 32'(wn2), 32'(w));
    chk({tag, "_err"}, 32'(err2), 32'(exp_err));
  endtask

  initial begin
    // Reset and idle
    repeat (2) @(posedge clk);
    #1;
    chk("rst_stall2", 32'(stall2), 32'd0);
    chk("rst_rw2", 32'(rw2), 32'd0);
    chk("rst_rd2", rd_2, 32'd0);
    chk("rst_alu2", alu2, 32'd0);
    chk("rst_err2", 32'(err2), 32'd0);
    chk("rst_stall0", 32'(stall0), 32'd0);
    chk("rst_rw0", 32'(rw0), 32'd0);
    rst = 1'b0;

    // Store then load at 0x10
    op2("sw10", 1'b0, 1'b1, 1'b0, 1'b0, 32'h10, 32'hDEADBEEF, 5'd0, 1'b0, 32'h0, 1'b0);
    op2("lw10", 1'b1, 1'b0, 1'b1, 1'b1, 32'h10, 32'h0, 5'd5, 1'b1, 32'hDEADBEEF, 1'b0);

    // Non-memory instruction passes with one cycle latency
    op2("add", 1'b0, 1'b0, 1'b0, 1'b1, 32'h1234, 32'h0, 5'd3, 1'b1, 32'h0, 1'b0);

    // Misaligned accesses
    op2("lw13", 1'b1, 1'b0, 1'b1, 1'b1, 32'h13, 32'h0, 5'd9, 1'b0, 32'h0, 1'b1);
    op2("sw20", 1'b0, 1'b1, 1'b0, 1'b0, 32'h20, 32'h55AA55AA, 5'd0, 1'b0, 32'h0, 1'b0);
    op2("sw22", 1'b0, 1'b1, 1'b0, 1'b0, 32'h22, 32'hBADBAD00, 5'd0, 1'b0, 32'h0, 1'b1);
    op2("lw20", 1'b1, 1'b0, 1'b1, 1'b1, 32'h20, 32'h0, 5'd4, 1'b1, 32'h55AA55AA, 1'b0);

    // Read and write together behaves as a store with zero read data
    op2("rw30", 1'b1, 1'b1, 1'b1, 1'b1, 32'h30, 32'h0BADF00D, 5'd6, 1'b1, 32'h0, 1'b0);
    op2("lw30", 1'b1, 1'b0, 1'b1, 1'b1, 32'h30, 32'h0, 5'd6, 1'b1, 32'h0BADF00D, 1'b0);

    // Address wraps: 0x1010 aliases word 4 in a 1024-word array
    op2("lwwrap", 1'b1, 1'b0, 1'b1, 1'b1, 32'h1010, 32'h0, 5'd2, 1'b1, 32'hDEADBEEF, 1'b0);

    // Reset in the middle of a store aborts it
    op2("sw40", 1'b0, 1'b1, 1'b0, 1'b0, 32'h40, 32'h11111111, 5'd0, 1'b0, 32'h0, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h40, 32'h22222222, 5'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("abort_stall", 32'(stall2), 32'd0);
    chk("abort_rw", 32'(rw2), 32'd0);
    chk("abort_alu", alu2, 32'd0);
    op2("lw40", 1'b1, 1'b0, 1'b1, 1'b1, 32'h40, 32'h0, 5'd8, 1'b1, 32'h11111111, 1'b0);

    // Zero wait states: back-to-back store/load on the 0-wait DUT
    drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h80, 32'hCAFEF00D, 5'd0);
    @(negedge clk);
    chk("w0_sw_stall", 32'(stall0), 32'd0);
    @(posedge clk); #1;
    chk("w0_sw_rw", 32'(rw0), 32'd0);
    chk("w0_sw_err", 32'(err0), 32'd0);
    drive(1'b1, 1'b0, 1'b1, 1'b1, 32'h80, 32'h0, 5'd7);
    @(negedge clk);
    chk("w0_lw_stall", 32'(stall0), 32'd0);
    @(posedge clk); #1;
    chk("w0_lw_rd", rd_0, 32'hCAFEF00D);
    chk("w0_lw_wn", 32'(wn0), 32'd7);
    chk("w0_lw_rw", 32'(rw0), 32'd1);
    chk("w0_lw_m2r", 32'(m2r0), 32'd1);
    chk("w0_lw_alu", alu0, 32'h80);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    @(posedge clk); #1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    bad++;
    $display("FAIL timeout observed=running expected=finished");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
